// File: rtl/example_load_store_unit_pkg.sv
// Shared constants for the load/store unit: data widths, RV32I funct3
// width/sign codes, the data-memory window and the LSU state encoding.
package example_load_store_unit_pkg;

  localparam int DATA_W = 32;

  // Data-memory window (inclusive bounds).
  localparam logic [DATA_W-1:0] DATA_BEGIN = 32'h0000_1000;
  localparam logic [DATA_W-1:0] DATA_END   = 32'h0000_1FFF;

  // RV32I load width/sign codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store width codes.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/example_load_store_unit_align.sv
// Combinational alignment for the LSU: byte enables and store-data
// replication, load-data shifting with sign/zero extension, and the
// misaligned / illegal-width classification of an access.
module example_lsu_align
  import example_load_store_unit_pkg::*;
(
  input  logic              write,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        byte_enable,
  output logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned,
  output logic              illegal
);

  function automatic logic [DATA_W-1:0] sext_byte(input logic [7:0] b);
    logic signed [7:0] s;
    s = signed'(b);
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sext_half(input logic [15:0] h);
    logic signed [15:0] s;
    s = signed'(h);
    return DATA_W'(s);
  endfunction

  logic [DATA_W-1:0] shifted;

  // Classify the access and build the store lane pattern for its width.
  always_comb begin
    byte_enable = 4'b0000;
    store_data  = wdata;
    misaligned  = 1'b0;
    illegal     = (funct3[1:0] == 2'b11) || (write ? funct3[2] : (funct3 == 3'b110));
    case (funct3[1:0])
      2'b00: begin
        byte_enable = 4'b0001 << addr;
        store_data  = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned  = addr[0];
        byte_enable = 4'b0011 << {addr[1], 1'b0};
        store_data  = {2{wdata[15:0]}};
      end
      2'b10: begin
        misaligned  = (addr != 2'b00);
        byte_enable = 4'b1111;
      end
      default: begin
        byte_enable = 4'b0000;
      end
    endcase
  end

  // Shift the addressed lane down and extend it to a full word.
  always_comb begin
    shifted   = rdata >> {addr, 3'b000};
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = sext_byte(shifted[7:0]);
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LH:   load_data = sext_half(shifted[15:0]);
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      F3_LW:   load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/example_load_store_unit.sv
// Multi-cycle load/store unit: accepts one request at a time, classifies
// it, drives the synchronous-read data bus and returns one response.
// Bus outputs are decoded from the state so an async reset drops every
// strobe immediately, which prevents partial writes.
module example_load_store_unit
  import example_load_store_unit_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] bus_address,
  output logic              bus_write_enable,
  output logic [3:0]        bus_byte_enable,
  output logic [DATA_W-1:0] bus_write_data,
  output logic              bus_read_enable,
  input  logic [DATA_W-1:0] bus_read_data
);

  lsu_state_e        state, state_nxt;

  logic              write_p1;
  logic [2:0]        funct3_p1;
  logic [DATA_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              error_p1;
  logic [DATA_W-1:0] rdata_p2;

  logic              idle;
  logic              accept;
  logic              out_of_range;
  logic              req_error;

  logic              al_write;
  logic [2:0]        al_funct3;
  logic [1:0]        al_addr;
  logic [DATA_W-1:0] al_wdata;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_store;
  logic [DATA_W-1:0] al_load;
  logic              al_mis;
  logic              al_ill;

  // The aligner classifies the live request while idle and serves the latched one afterwards.
  always_comb begin
    idle      = (state == LSU_IDLE);
    al_write  = idle ? req_write            : write_p1;
    al_funct3 = idle ? req_funct3           : funct3_p1;
    al_addr   = idle ? req_address[1:0]     : addr_p1[1:0];
    al_wdata  = idle ? req_wdata            : wdata_p1;
  end

  example_lsu_align u_align (
    .write       (al_write),
    .funct3      (al_funct3),
    .addr        (al_addr),
    .wdata       (al_wdata),
    .rdata       (bus_read_data),
    .byte_enable (al_be),
    .store_data  (al_store),
    .load_data   (al_load),
    .misaligned  (al_mis),
    .illegal     (al_ill)
  );

  // Handshake and error classification of the incoming request.
  always_comb begin
    out_of_range = CHECK_RANGE && ((req_address < DATA_BEGIN) || (req_address > DATA_END));
    req_error    = al_mis | al_ill | out_of_range;
    req_ready    = idle & ~reset;
    accept       = req_ready & req_valid;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LSU_IDLE;
    else       state <= state_nxt;
  end

  // Next state and bus/response outputs, all zero unless the state drives them.
  always_comb begin
    state_nxt        = state;
    bus_address      = '0;
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
    bus_byte_enable  = 4'b0000;
    bus_write_data   = '0;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (accept) state_nxt = req_error ? LSU_RESP : LSU_ISSUE;
      end
      LSU_ISSUE: begin
        bus_address = {addr_p1[DATA_W-1:2], 2'b00};
        if (write_p1) begin
          bus_write_enable = 1'b1;
          bus_byte_enable  = al_be;
          bus_write_data   = al_store;
          state_nxt        = LSU_RESP;
        end else begin
          bus_read_enable  = 1'b1;
          state_nxt        = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        bus_address     = {addr_p1[DATA_W-1:2], 2'b00};
        bus_read_enable = 1'b1;
        state_nxt       = LSU_RESP;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        resp_error = error_p1;
        state_nxt  = LSU_IDLE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  // ---- stage p1: latched request ----
  // Capture the request and its classification on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_p1  <= 1'b0;
      funct3_p1 <= 3'b000;
      addr_p1   <= '0;
      wdata_p1  <= '0;
      error_p1  <= 1'b0;
    end else if (accept) begin
      write_p1  <= req_write;
      funct3_p1 <= req_funct3;
      addr_p1   <= req_address;
      wdata_p1  <= req_wdata;
      error_p1  <= req_error;
    end
  end

  // ---- stage p2: response data ----
  // Update only when entering RESP so the value holds between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_p2 <= '0;
    end else if ((accept && req_error) || (state == LSU_ISSUE && write_p1)) begin
      rdata_p2 <= '0;
    end else if (state == LSU_WAIT) begin
      rdata_p2 <= al_load;
    end
  end

  assign resp_rdata = rdata_p2;

endmodule

// File: tb/tb_example_load_store_unit.sv
// Self-checking bench for example_load_store_unit: a synchronous-read
// memory fixture on the bus, a request-level reference model checked on
// every falling edge, directed scenarios with literal expectations and a
// randomized request stream.
module tb_example_load_store_unit;

  localparam logic [31:0] DB = 32'h0000_1000;
  localparam logic [31:0] DE = 32'h0000_1FFF;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] bus_address;
  logic        bus_write_enable;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic        bus_read_enable;
  logic [31:0] bus_read_data;

  int tests = 0;
  int fails = 0;

  example_load_store_unit #(.CHECK_RANGE(1'b1)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_error       (resp_error),
    .resp_rdata       (resp_rdata),
    .bus_address      (bus_address),
    .bus_write_enable (bus_write_enable),
    .bus_byte_enable  (bus_byte_enable),
    .bus_write_data   (bus_write_data),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int idx);
    return (32'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory fixture: byte-enabled writes, read data one cycle after the address.
  logic [31:0] fmem [0:1023];
  bit          fwr  [0:1023];

  function automatic logic [31:0] fread(input logic [9:0] i);
    return fwr[i] ? fmem[i] : init_word(int'(i));
  endfunction

  always @(posedge clock) begin
    if (bus_write_enable) begin
      fmem[bus_address[11:2]] <= merge(fread(bus_address[11:2]), bus_write_data, bus_byte_enable);
      fwr[bus_address[11:2]]  <= 1'b1;
    end
    bus_read_data <= fread(bus_address[11:2]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model state (request level).
  logic [31:0] gmem [0:1023];
  bit          m_busy;
  int          m_k, m_lat, m_kind;       // kind: 0 error, 1 store, 2 load
  logic [31:0] m_addr, m_data, m_resp_rd, hold;
  logic [3:0]  m_be;
  bit          m_err;
  int          n_acc, n_done, n_abort, n_dut_resp;

  // Model: predict and check outputs every cycle, then advance to the next edge.
  initial begin : compare
    logic [31:0] a, w, sh;
    logic [2:0]  f;
    int          sz, off;
    bit          ill, mis, oor, exp_we, exp_re, exp_rv;
    for (int i = 0; i < 1024; i++) gmem[i] = init_word(i);
    m_busy = 0; m_k = 0; m_lat = 0; m_kind = 0; hold = '0;
    n_acc = 0; n_done = 0; n_abort = 0; n_dut_resp = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_we", bus_write_enable, 0);
        chk("rst_re", bus_read_enable, 0);
        chk("rst_be", bus_byte_enable, 0);
        chk("rst_addr", bus_address, 0);
        chk("rst_wdata", bus_write_data, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        if (m_busy) n_abort++;
        m_busy = 0;
        hold   = '0;
      end else begin
        exp_we = m_busy && m_kind == 1 && m_k == 1;
        exp_re = m_busy && m_kind == 2 && (m_k == 1 || m_k == 2);
        exp_rv = m_busy && m_k == m_lat;
        if (exp_rv) hold = m_resp_rd;
        chk("ready", req_ready, !m_busy);
        chk("write_enable", bus_write_enable, exp_we);
        chk("read_enable", bus_read_enable, exp_re);
        chk("resp_valid", resp_valid, exp_rv);
        chk("resp_rdata_hold", resp_rdata, hold);
        if (!exp_we && !exp_re) chk("idle_be", bus_byte_enable, 0);
        if (exp_we) begin
          chk("st_addr", bus_address, {m_addr[31:2], 2'b00});
          chk("st_be", bus_byte_enable, m_be);
          chk("st_data", bus_write_data, m_data);
        end
        if (exp_re) chk("ld_addr", bus_address, {m_addr[31:2], 2'b00});
        if (exp_rv) chk("resp_error", resp_error, m_err);
        if (resp_valid) n_dut_resp++;
        if (m_busy) begin
          if (m_kind == 1 && m_k == 1)
            gmem[m_addr[11:2]] = merge(gmem[m_addr[11:2]], m_data, m_be);
          if (m_k == m_lat) begin
            m_busy = 0;
            n_done++;
          end else begin
            m_k++;
          end
        end else if (req_valid) begin
          a   = req_address;
          f   = req_funct3;
          sz  = int'(f[1:0]);
          off = int'(a[1:0]);
          ill = (sz == 3) || (req_write ? (f[2] == 1'b1) : (f == 3'b110));
          mis = (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
          oor = (a < DB) || (a > DE);
          m_addr = a;
          m_busy = 1;
          m_k    = 1;
          n_acc++;
          if (ill || mis || oor) begin
            m_kind = 0; m_lat = 1; m_err = 1; m_resp_rd = '0;
          end else if (req_write) begin
            m_kind = 1; m_lat = 2; m_err = 0; m_resp_rd = '0;
            if (sz == 0) begin
              m_be = 4'(4'b0001 << off); m_data = {4{req_wdata[7:0]}};
            end else if (sz == 1) begin
              m_be = 4'(4'b0011 << off); m_data = {2{req_wdata[15:0]}};
            end else begin
              m_be = 4'b1111; m_data = req_wdata;
            end
          end else begin
            m_kind = 2; m_lat = 3; m_err = 0;
            w  = gmem[a[11:2]];
            sh = w >> (8 * off);
            case (f)
              3'b000:  m_resp_rd = {{24{sh[7]}}, sh[7:0]};
              3'b100:  m_resp_rd = {24'h0, sh[7:0]};
              3'b001:  m_resp_rd = {{16{sh[15]}}, sh[15:0]};
              3'b101:  m_resp_rd = {16'h0, sh[15:0]};
              default: m_resp_rd = sh;
            endcase
          end
        end
      end
    end
  end

  // Present a request and hold it until the accepting edge has passed.
  task automatic issue(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1; req_write = w; req_funct3 = f; req_address = a; req_wdata = d;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready && n < 20);
    if (!req_ready) note_fail("accept_timeout");
    @(posedge clock); #1;
  endtask

  task automatic wait_resp(output logic err, output logic [31:0] rd,
                           output logic [3:0] be_seen, output logic [31:0] wd_seen);
    int n;
    bit got;
    n = 0; got = 0; err = 1'bx; rd = 'x; be_seen = 4'b0000; wd_seen = '0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if (bus_write_enable) begin
        be_seen = bus_byte_enable;
        wd_seen = bus_write_data;
      end
      if (resp_valid) begin
        got = 1; err = resp_error; rd = resp_rdata;
      end
    end
    if (!got) note_fail("resp_timeout");
    @(posedge clock); #1;
  endtask

  task automatic txn(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                     output logic err, output logic [31:0] rd,
                     output logic [3:0] be_seen, output logic [31:0] wd_seen);
    issue(w, f, a, d);
    req_valid = 1'b0;
    wait_resp(err, rd, be_seen, wd_seen);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        e;
    logic [31:0] rd, wd, a;
    logic [3:0]  be;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_address = '0; req_wdata = '0;
    #1;
    chk("t0_ready", req_ready, 0);
    chk("t0_resp_valid", resp_valid, 0);
    chk("t0_resp_rdata", resp_rdata, 0);
    chk("t0_we", bus_write_enable, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset during the ISSUE cycle of a store: nothing may be written.
    issue(1'b1, 3'b010, DB, 32'hDEAD_BEEF);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    txn(1'b0, 3'b010, DB, 32'h0, e, rd, be, wd);
    chk("t1_lw_prior", rd, init_word(0));

    // Byte store into a word, then read the merged word.
    txn(1'b1, 3'b010, DB, 32'h1122_3344, e, rd, be, wd);
    chk("t2_sw_err", e, 0);
    txn(1'b1, 3'b000, DB + 1, 32'h0000_00AA, e, rd, be, wd);
    chk("t2_sb_be", be, 4'b0010);
    chk("t2_sb_wdata", wd, 32'hAAAA_AAAA);
    chk("t2_sb_rdata", rd, 0);
    txn(1'b0, 3'b010, DB, 32'h0, e, rd, be, wd);
    chk("t2_lw", rd, 32'h1122_AA44);

    // Sub-word loads with sign and zero extension.
    txn(1'b0, 3'b000, DB + 1, 32'h0, e, rd, be, wd);
    chk("t3_lb", rd, 32'hFFFF_FFAA);
    txn(1'b0, 3'b100, DB + 1, 32'h0, e, rd, be, wd);
    chk("t3_lbu", rd, 32'h0000_00AA);
    txn(1'b0, 3'b001, DB + 2, 32'h0, e, rd, be, wd);
    chk("t3_lh", rd, 32'h0000_1122);
    txn(1'b0, 3'b101, DB + 2, 32'h0, e, rd, be, wd);
    chk("t3_lhu", rd, 32'h0000_1122);

    // Misaligned, illegal and out-of-range requests.
    txn(1'b0, 3'b010, DB + 2, 32'h0, e, rd, be, wd);
    chk("t4_lw_mis_err", e, 1);
    chk("t4_lw_mis_rdata", rd, 0);
    txn(1'b1, 3'b001, DB + 3, 32'h5555_6666, e, rd, be, wd);
    chk("t4_sh_mis_err", e, 1);
    chk("t4_sh_mis_rdata", rd, 0);
    txn(1'b0, 3'b111, DB, 32'h0, e, rd, be, wd);
    chk("t5_ill_err", e, 1);
    txn(1'b0, 3'b010, DE + 1, 32'h0, e, rd, be, wd);
    chk("t5_oor_err", e, 1);
    chk("t5_oor_rdata", rd, 0);

    // Continuous valid with alternating stores and loads.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) issue(1'b1, 3'b010, DB + 32'(4 * i), $urandom);
      else            issue(1'b0, 3'b010, DB + 32'(4 * (i - 1)), 32'h0);
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;

    // Randomized request stream.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 1) ? 32'h0000_2000 + 32'($urandom_range(0, 16'hFFFF))
                                        : 32'($urandom_range(0, 12'hFFF));
      else
        a = DB + 32'($urandom_range(0, 12'hFFF));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(posedge clock);
        #1;
      end
    end
    req_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;

    chk("resp_count", n_dut_resp, n_done);
    chk("accept_count", n_done, n_acc - n_abort);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
